// File: rtl/apb_cmd_drain.sv
// APB3 master that drains the async command FIFO one transfer at a time.
// Each popped command runs as one APB transaction and produces one completion word.
module apb_cmd_drain #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16,
    parameter int CMD_W       = 1 + ADDR_W + DATA_W,
    parameter int RSP_W       = DATA_W + 3
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              cmd_rempty,
    output logic              cmd_rinc,
    input  logic [CMD_W-1:0]  cmd_rdata,
    input  logic              rsp_wfull,
    output logic              rsp_winc,
    output logic [RSP_W-1:0]  rsp_wdata,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    // A zero-width counter is illegal, so keep one bit when the timeout is disabled.
    localparam int               CNT_W     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int               TO_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_LAST_I);
    localparam bit               TO_EN     = (TIMEOUT_CYC > 0);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             to_hit;
    logic [DATA_W-1:0] rd_sel;

    assign to_hit = TO_EN && (cnt == TO_LAST);
    assign rd_sel = pwrite ? {DATA_W{1'b0}} : prdata;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!cmd_rempty) state_nxt = POP;
            POP:     state_nxt = LOAD;
            LOAD:    state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready || to_hit) state_nxt = RESP;
            RESP:    if (!rsp_wfull) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes decode straight from state so an async reset kills them immediately.
    assign cmd_rinc = (state == POP);
    assign psel     = (state == SETUP) || (state == ACCESS);
    assign penable  = (state == ACCESS);
    assign rsp_winc = (state == RESP) && !rsp_wfull;
    assign busy     = (state != IDLE);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_wdata <= '0;
            cnt       <= '0;
        end else begin
            if (state == LOAD) begin
                pwrite <= cmd_rdata[CMD_W-1];
                paddr  <= cmd_rdata[DATA_W +: ADDR_W];
                pwdata <= cmd_rdata[DATA_W-1:0];
                cnt    <= '0;
            end
            if (state == ACCESS) begin
                if (pready) begin
                    rsp_wdata <= {1'b0, pslverr, pwrite, rd_sel};
                end else if (to_hit) begin
                    rsp_wdata <= {1'b1, 1'b0, pwrite, {DATA_W{1'b0}}};
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_cmd_drain.sv
// Scoreboard bench for apb_cmd_drain: directed commands, queued expected responses,
// a modelled command FIFO and APB slave, and a negedge monitor.
module tb_apb_cmd_drain;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CMD_W  = 1 + ADDR_W + DATA_W;
    localparam int RSP_W  = DATA_W + 3;

    logic              rclk = 1'b0;
    logic              rrst_n = 1'b0;
    logic              cmd_rempty;
    logic              cmd_rinc;
    logic [CMD_W-1:0]  cmd_rdata;
    logic              rsp_wfull;
    logic              rsp_winc;
    logic [RSP_W-1:0]  rsp_wdata;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;
    logic              busy;

    always #5 rclk = ~rclk;

    apb_cmd_drain #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYC(16)
    ) dut (
        .rclk(rclk),
        .rrst_n(rrst_n),
        .cmd_rempty(cmd_rempty),
        .cmd_rinc(cmd_rinc),
        .cmd_rdata(cmd_rdata),
        .rsp_wfull(rsp_wfull),
        .rsp_winc(rsp_winc),
        .rsp_wdata(rsp_wdata),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .prdata(prdata),
        .pready(pready),
        .pslverr(pslverr),
        .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    logic [RSP_W-1:0] exp_q[$];
    logic [CMD_W-1:0] cmd_q[$];

    int pop_n = 0, push_n = 0, acc_cyc = 0, addr_viol = 0, safety_viol = 0, full_viol = 0;
    int cyc = 0, t_ne = 0, t_psel = 0, t_push = 0, idle_act = 0;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_write;

    logic              slv_stuck = 1'b0;
    int                slv_wait = 0;
    logic [DATA_W-1:0] slv_rdata = '0;
    logic              slv_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [CMD_W-1:0] cmd, input logic [RSP_W-1:0] rsp);
        cmd_q.push_back(cmd);
        exp_q.push_back(rsp);
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || cmd_q.size() != 0 || busy) && n < max_cyc) begin
            @(posedge rclk);
            n++;
        end
        checks++;
        if (n >= max_cyc) begin
            failures++;
            $display("FAIL wait_done: still busy after %0d cycles, %0d responses outstanding",
                     n, exp_q.size());
        end
    endtask

    // Monitor: scoreboard pops on every push plus protocol bookkeeping.
    initial begin
        logic [RSP_W-1:0] e;
        forever begin
            @(negedge rclk);
            cyc++;
            if (rrst_n) begin
                if (cmd_rinc) begin
                    pop_n++;
                    if (cmd_rempty) safety_viol++;
                end
                if (rsp_winc && rsp_wfull) full_viol++;
                if (!busy && !cmd_rempty) t_ne = cyc;
                if (cmd_rinc || psel || busy) idle_act++;
                if (psel && !penable) begin
                    t_psel    = cyc;
                    acc_cyc   = 0;
                    acc_addr  = paddr;
                    acc_write = pwrite;
                    acc_wdata = pwdata;
                end
                if (psel && penable) begin
                    acc_cyc++;
                    if (paddr !== acc_addr || pwrite !== acc_write || pwdata !== acc_wdata)
                        addr_viol++;
                end
                if (rsp_winc) begin
                    push_n++;
                    t_push = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rsp_unexpected: got 0x%0h expected no push", rsp_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_word", rsp_wdata, e);
                    end
                end
            end
        end
    end

    // APB slave: ready after slv_wait ACCESS cycles unless stuck; prdata tagged with paddr.
    initial begin
        int slv_acc;
        slv_acc = 0;
        pready  = 1'b0;
        prdata  = '0;
        pslverr = 1'b0;
        forever begin
            @(negedge rclk);
            if (psel && penable) begin
                if (!slv_stuck && slv_acc >= slv_wait) begin
                    pready  = 1'b1;
                    prdata  = slv_rdata ^ paddr;
                    pslverr = slv_err;
                end else begin
                    pready  = 1'b0;
                    prdata  = '0;
                    pslverr = 1'b0;
                end
                slv_acc++;
            end else begin
                pready  = 1'b0;
                prdata  = '0;
                pslverr = 1'b0;
                slv_acc = 0;
            end
        end
    end

    // Command FIFO: data appears the cycle after the pop edge, empty flag is registered.
    initial begin
        logic pop;
        cmd_rempty = 1'b1;
        cmd_rdata  = '0;
        forever begin
            @(negedge rclk);
            pop = cmd_rinc;
            @(posedge rclk);
            #1;
            if (pop && cmd_q.size() > 0) cmd_rdata = cmd_q.pop_front();
            cmd_rempty = (cmd_q.size() == 0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, p0, h0, n;
        rsp_wfull = 1'b0;
        rrst_n    = 1'b0;
        repeat (3) @(posedge rclk);
        #1;
        check("rst_ctrl", {psel, penable, cmd_rinc, rsp_winc, busy, pwrite}, 0);
        check("rst_paddr", paddr, 0);
        check("rst_rsp", rsp_wdata, 0);
        @(negedge rclk);
        rrst_n = 1'b1;

        // Empty FIFO: nothing may move.
        base = idle_act;
        p0   = pop_n;
        repeat (30) @(posedge rclk);
        check("empty_activity", idle_act - base, 0);
        check("empty_pops", pop_n - p0, 0);

        // Single write, slave ready at once.
        slv_wait  = 0;
        slv_err   = 1'b0;
        slv_rdata = 32'hFFFF_0000;
        p0 = pop_n;
        @(negedge rclk);
        send({1'b1, 32'h0000_0010, 32'hA5A5_0001}, 35'h1_0000_0000);
        wait_done(50);
        check("t1_pops", pop_n - p0, 1);
        check("t1_psel_latency", t_psel - t_ne, 3);
        check("t1_push_latency", t_push - t_ne, 5);
        check("t1_acc_cycles", acc_cyc, 1);
        check("t1_paddr_hold", paddr, 32'h10);

        // Read with three wait states and a slave error.
        slv_wait  = 3;
        slv_err   = 1'b1;
        slv_rdata = 32'hDEAD_BEEF ^ 32'h20;
        @(negedge rclk);
        send({1'b0, 32'h0000_0020, 32'h0}, 35'h2_DEAD_BEEF);
        wait_done(50);
        check("t2_acc_cycles", acc_cyc, 4);
        check("t2_addr_stable", addr_viol, 0);

        // Read that never completes: timeout.
        slv_stuck = 1'b1;
        slv_err   = 1'b0;
        @(negedge rclk);
        send({1'b0, 32'h0000_0030, 32'h0}, 35'h4_0000_0000);
        wait_done(100);
        check("t3_acc_cycles", acc_cyc, 16);
        check("t3_psel_low", {psel, penable}, 0);

        // Four queued commands, response FIFO full while the second one responds.
        slv_stuck = 1'b0;
        slv_wait  = 0;
        slv_rdata = 32'h1111_0000;
        p0 = pop_n;
        h0 = push_n;
        @(negedge rclk);
        send({1'b1, 32'h0000_0100, 32'h0000_0001}, 35'h1_0000_0000);
        send({1'b0, 32'h0000_0104, 32'h0},          35'h0_1111_0104);
        send({1'b1, 32'h0000_0108, 32'h0000_0003}, 35'h1_0000_0000);
        send({1'b0, 32'h0000_010C, 32'h0},          35'h0_1111_010C);
        n = 0;
        while (push_n == h0 && n < 50) begin
            @(posedge rclk);
            n++;
        end
        check("t4_first_push_seen", push_n - h0, 1);
        #1;
        rsp_wfull = 1'b1;
        repeat (9) @(posedge rclk);
        #1;
        check("t4_hold_busy", busy, 1);
        check("t4_hold_no_push", rsp_winc, 0);
        check("t4_hold_pops", pop_n - p0, 2);
        @(posedge rclk);
        #1;
        rsp_wfull = 1'b0;
        wait_done(100);
        check("t4_pops", pop_n - p0, 4);
        check("t4_pushes", push_n - h0, 4);

        // Reset in the middle of ACCESS.
        slv_stuck = 1'b1;
        @(negedge rclk);
        send({1'b0, 32'h0000_0040, 32'h0}, 35'h4_0000_0000);
        n = 0;
        while (!(psel && penable) && n < 50) begin
            @(posedge rclk);
            n++;
        end
        check("t5_reached_access", {psel, penable}, 2'b11);
        @(posedge rclk);
        #2;
        rrst_n = 1'b0;
        #1;
        check("t5_rst_ctrl", {psel, penable, cmd_rinc, rsp_winc, busy}, 0);
        exp_q.delete();
        slv_stuck = 1'b0;
        @(negedge rclk);
        rrst_n = 1'b1;
        h0 = push_n;
        repeat (10) @(posedge rclk);
        #1;
        check("t5_idle_after", busy, 0);
        check("t5_no_push", push_n - h0, 0);

        // Recovery after reset.
        @(negedge rclk);
        send({1'b1, 32'h0000_0050, 32'h0000_0055}, 35'h1_0000_0000);
        wait_done(50);
        check("pop_safety", safety_viol, 0);
        check("push_while_full", full_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
